// File: rtl/inst_fetch_mem.sv
// Clocked instruction memory for the fetch stage: 1-cycle read, req/valid/hold handshake,
// runtime program-load port and address-fault flag. Define INSTMEM_PARITY_EN for per-word parity and ParErr.
module inst_fetch_mem #(
    parameter int          ADDR_W    = 32,
    parameter int          DEPTH     = 64,
    parameter              INIT_FILE = "",
    parameter logic [31:0] NOP       = 32'h0,
    localparam int         IDX_W     = $clog2(DEPTH)
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Req,
    input  logic [ADDR_W-1:0] Addr,
    output logic              Ready,
    output logic              Valid,
    output logic [31:0]       Inst,
    output logic              Fault,
`ifdef INSTMEM_PARITY_EN
    output logic              ParErr,
`endif
    input  logic              Hold,
    input  logic              LdWe,
    input  logic [IDX_W-1:0]  LdAddr,
    input  logic [31:0]       LdData
);

    typedef enum logic [1:0] {IDLE, RESP, STALL} state_t;

    state_t            state_q, state_d;
    logic [31:0]       inst_q, inst_d;
    logic              fault_q, fault_d;
    logic [31:0]       mem [DEPTH];
    logic [IDX_W-1:0]  idx;
    logic              misaligned, out_of_range, accept, valid;

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;
    end

    assign idx          = Addr[IDX_W+1:2];
    assign misaligned   = |Addr[1:0];
    // Any address bit above the word-index field means the word lies past the end; no wrap.
    assign out_of_range = |(Addr >> (IDX_W + 2));
    assign valid        = (state_q != IDLE);
    assign Ready        = ~Rst & ~LdWe & ~(valid & Hold);
    assign accept       = Req & Ready;

    always_comb begin
        state_d = state_q;
        inst_d  = inst_q;
        fault_d = fault_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = RESP;
            end
            RESP, STALL: begin
                if (Hold)        state_d = STALL;
                else if (accept) state_d = RESP;
                else             state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            fault_d = misaligned | out_of_range;
            inst_d  = fault_d ? NOP : mem[idx];
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
            inst_q  <= 32'h0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            inst_q  <= inst_d;
            fault_q <= fault_d;
        end
    end

    // Loads are independent of Rst so a program can be written while the core is held in reset.
    always_ff @(posedge Clk) begin
        if (LdWe) mem[LdAddr] <= LdData;
    end

    assign Valid = valid;
    assign Inst  = inst_q;
    assign Fault = fault_q;

`ifdef INSTMEM_PARITY_EN
    logic par_mem [DEPTH];
    logic par_err_q, par_err_d;

    initial begin
        for (int i = 0; i < DEPTH; i++) par_mem[i] = ^mem[i];
    end

    always @(posedge Clk) begin
        if (LdWe) par_mem[LdAddr] <= ^LdData;
    end

    always_comb begin
        par_err_d = par_err_q;
        if (accept) par_err_d = ~(misaligned | out_of_range) & (par_mem[idx] != ^mem[idx]);
    end

    always_ff @(posedge Clk) begin
        if (Rst) par_err_q <= 1'b0;
        else     par_err_q <= par_err_d;
    end

    assign ParErr = par_err_q;

    // Corrupts the stored parity of one word so ParErr can be exercised.
    task flip_parity(input logic [IDX_W-1:0] i);
        par_mem[i] = ~par_mem[i];
    endtask
`endif

endmodule
